// File: rtl/spi_sd_master_pkg.sv
// Shared definitions for the SD-card SPI master: register map, bit positions,
// FSM states and reset constants.
package spi_sd_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } spi_state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int unsigned CTRL_NSD0 = 0;
   localparam int unsigned CTRL_NSD1 = 1;
   localparam int unsigned CTRL_AUTO = 7;

   localparam logic [7:0] RX_RESET = 8'hFF;
   localparam logic [7:0] TX_AUTO  = 8'hFF;

   function automatic logic [7:0] ctrl_byte(input logic auto_en, input logic nsd1, input logic nsd0);
      return {auto_en, 5'b0, nsd1, nsd0};
   endfunction

   function automatic logic [7:0] status_byte(input logic busy, input logic ovr);
      return {busy, ovr, 6'b0};
   endfunction

endpackage

// File: rtl/spi_sd_master_halfper_tick.sv
// Loadable down-counter producing one tick per SCLK half period; keeps its own
// copy of the period so DIV changes only take effect at the next load.
module spi_sd_master_halfper_tick #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_period,
   input  logic             i_run,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_period;
   logic [DIV_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period <= '0;
         r_count  <= '0;
      end else if (i_load) begin
         r_period <= i_period;
         r_count  <= i_period;
      end else if (i_run) begin
         if (r_count == '0) r_count <= r_period;
         else               r_count <= r_count - DIV_W'(1);
      end
   end

   assign o_tick = i_run && (r_count == '0);

endmodule

// File: rtl/spi_sd_master.sv
// Byte-wide mode-0 SPI master for the SD slots: CTRL/DATA/DIV/STATUS registers,
// transfer FSM and shift registers.
module spi_sd_master
   import spi_sd_master_pkg::*;
#(
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned RESET_DIV = 59
) (
   input  logic       MHZ48,
   input  logic       nRES,
   input  logic       REG_STB,
   input  logic       REG_RW,
   input  logic [1:0] REG_A,
   input  logic [7:0] REG_DI,
   output logic [7:0] REG_DO,
   output logic       SCLK,
   output logic       MOSI,
   input  logic       MISO,
   output logic       nSD0,
   output logic       nSD1,
   output logic       BUSY
);

   spi_state_t       r_state;
   logic             r_nsd0, r_nsd1, r_auto, r_ovr;
   logic             r_busy, r_sclk, r_mosi;
   logic [2:0]       r_bit;
   logic [7:0]       r_tx_sh, r_rx_sh, r_rx;
   logic [DIV_W-1:0] r_div;

   logic             w_data_acc, w_start, w_run, w_tick, w_stat_rd;
   logic [7:0]       w_tx;

   // A DATA write, or a DATA read with AUTO set, requests a transfer.
   assign w_data_acc = REG_STB && (REG_A == REG_DATA) && (!REG_RW || r_auto);
   assign w_start    = w_data_acc && (r_state == ST_IDLE);
   assign w_stat_rd  = REG_STB && REG_RW && (REG_A == REG_STATUS);
   assign w_tx       = REG_RW ? TX_AUTO : REG_DI;
   assign w_run      = (r_state != ST_IDLE);

   spi_sd_master_halfper_tick #(.DIV_W(DIV_W)) u_tick (
      .clk      (MHZ48),
      .rst_n    (nRES),
      .i_load   (w_start),
      .i_period (r_div),
      .i_run    (w_run),
      .o_tick   (w_tick)
   );

   always_ff @(posedge MHZ48 or negedge nRES) begin
      if (!nRES) begin
         r_nsd0 <= 1'b1;
         r_nsd1 <= 1'b1;
         r_auto <= 1'b0;
         r_div  <= DIV_W'(RESET_DIV);
         r_ovr  <= 1'b0;
      end else begin
         if (REG_STB && !REG_RW && (REG_A == REG_CTRL)) begin
            r_nsd0 <= REG_DI[CTRL_NSD0];
            r_nsd1 <= REG_DI[CTRL_NSD1];
            r_auto <= REG_DI[CTRL_AUTO];
         end
         if (REG_STB && !REG_RW && (REG_A == REG_DIV))
            r_div <= REG_DI[DIV_W-1:0];
         if (w_data_acc && w_run) r_ovr <= 1'b1;
         else if (w_stat_rd)      r_ovr <= 1'b0;
      end
   end

   always_ff @(posedge MHZ48 or negedge nRES) begin
      if (!nRES) begin
         r_state <= ST_IDLE;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b1;
         r_busy  <= 1'b0;
         r_bit   <= '0;
         r_tx_sh <= '0;
         r_rx_sh <= '0;
         r_rx    <= RX_RESET;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_tx_sh <= w_tx;
                  r_bit   <= '0;
                  r_mosi  <= w_tx[7];
                  r_busy  <= 1'b1;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP, ST_LOW: begin
               if (w_tick) begin
                  r_sclk  <= 1'b1;
                  r_rx_sh <= {r_rx_sh[6:0], MISO};
                  r_state <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (w_tick) begin
                  r_sclk <= 1'b0;
                  // r_bit counts completed high phases minus one, so 7 marks the eighth.
                  if (r_bit == 3'd7) begin
                     r_rx    <= r_rx_sh;
                     r_mosi  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                     r_mosi  <= r_tx_sh[6];
                     r_state <= ST_LOW;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      REG_DO = '0;
      case (REG_A)
         REG_CTRL:   REG_DO = ctrl_byte(r_auto, r_nsd1, r_nsd0);
         REG_DATA:   REG_DO = r_rx;
         REG_DIV:    REG_DO = 8'(r_div);
         REG_STATUS: REG_DO = status_byte(r_busy, r_ovr);
         default:    REG_DO = '0;
      endcase
   end

   assign SCLK = r_sclk;
   assign MOSI = r_mosi;
   assign nSD0 = r_nsd0;
   assign nSD1 = r_nsd1;
   assign BUSY = r_busy;

endmodule

// File: tb/tb_spi_sd_master.sv
// Randomized self-checking bench for spi_sd_master; expectations come from the
// byte-level SPI rules (MSB-first bits, 16*(DIV+1) busy cycles, RX = sampled bits).
module tb_spi_sd_master;

   logic       clk = 1'b0;
   logic       nres;
   logic       stb, rw;
   logic [1:0] a;
   logic [7:0] di, reg_do;
   logic       sclk, mosi, miso, nsd0, nsd1, busy;

   logic       loopback;
   logic       miso_drv;
   logic [7:0] miso_pat;
   logic [7:0] exp_rx;
   int         checks = 0;
   int         errors = 0;

   assign miso = loopback ? mosi : miso_drv;

   always #5 clk = ~clk;

   spi_sd_master #(.DIV_W(8), .RESET_DIV(59)) dut (
      .MHZ48   (clk),
      .nRES    (nres),
      .REG_STB (stb),
      .REG_RW  (rw),
      .REG_A   (a),
      .REG_DI  (di),
      .REG_DO  (reg_do),
      .SCLK    (sclk),
      .MOSI    (mosi),
      .MISO    (miso),
      .nSD0    (nsd0),
      .nSD1    (nsd1),
      .BUSY    (busy)
   );

   // One-cycle strobe; read data is captured before the strobe edge.
   task automatic bus_access(input logic r, input logic [1:0] addr, input logic [7:0] data,
                             output logic [7:0] rd);
      @(negedge clk);
      stb = 1'b1; rw = r; a = addr; di = data;
      #1 rd = reg_do;
      @(negedge clk);
      stb = 1'b0; rw = 1'b1; a = 2'd0; di = 8'd0;
   endtask

   task automatic reg_wr(input logic [1:0] addr, input logic [7:0] data);
      logic [7:0] dummy;
      bus_access(1'b0, addr, data, dummy);
   endtask

   task automatic reg_rd(input logic [1:0] addr, output logic [7:0] rd);
      bus_access(1'b1, addr, 8'd0, rd);
   endtask

   task automatic wait_idle(input string name);
      int guard;
      guard = 0;
      while (busy === 1'b1 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 5000) begin
         errors++;
         $display("FAIL %s idle_timeout busy still %b after %0d cycles", name, busy, guard);
      end
   endtask

   // Observes one transfer from the first busy cycle; drives MISO from miso_pat.
   task automatic monitor(output int busy_n, output logic [7:0] mbits, output int rises,
                          output int hmin, output int hmax, output int lmin, output int lmax);
      int   run, guard;
      logic lvl;
      busy_n = 0; mbits = 8'd0; rises = 0;
      hmin = 100000; hmax = 0; lmin = 100000; lmax = 0;
      lvl = sclk; run = 0; guard = 0;
      while (busy === 1'b1 && guard < 20000) begin
         if (sclk !== lvl) begin
            if (lvl) begin
               if (run < hmin) hmin = run;
               if (run > hmax) hmax = run;
            end else begin
               if (run < lmin) lmin = run;
               if (run > lmax) lmax = run;
            end
            if (sclk === 1'b1) begin
               rises++;
               mbits = {mbits[6:0], mosi};
               if (rises < 8) miso_drv = miso_pat[7-rises];
            end
            lvl = sclk;
            run = 0;
         end
         run++; busy_n++; guard++;
         @(negedge clk);
      end
      if (lvl) begin
         if (run < hmin) hmin = run;
         if (run > hmax) hmax = run;
      end
      if (guard >= 20000) begin
         checks++; errors++;
         $display("FAIL monitor busy_timeout after %0d cycles", guard);
      end
   endtask

   task automatic do_xfer(input int div, input logic set_div, input logic [7:0] tx,
                          input logic lb, input logic [7:0] pat, input string name);
      int         busy_n, rises, hmin, hmax, lmin, lmax;
      logic [7:0] mbits, rd;
      if (set_div) reg_wr(2'd2, 8'(div));
      loopback = lb; miso_pat = pat; miso_drv = pat[7];
      reg_wr(2'd1, tx);
      monitor(busy_n, mbits, rises, hmin, hmax, lmin, lmax);
      exp_rx = lb ? tx : pat;
      checks++;
      if (busy_n !== 16*(div+1)) begin
         errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_n, 16*(div+1));
      end
      checks++;
      if (rises !== 8) begin
         errors++; $display("FAIL %s sclk_pulses got %0d exp 8", name, rises);
      end
      checks++;
      if (mbits !== tx) begin
         errors++; $display("FAIL %s mosi_bits got %h exp %h", name, mbits, tx);
      end
      checks++;
      if (hmin !== div+1 || hmax !== div+1) begin
         errors++; $display("FAIL %s sclk_high got %0d..%0d exp %0d", name, hmin, hmax, div+1);
      end
      checks++;
      if (lmin !== div+1 || lmax !== div+1) begin
         errors++; $display("FAIL %s sclk_low got %0d..%0d exp %0d", name, lmin, lmax, div+1);
      end
      checks++;
      if (mosi !== 1'b1 || sclk !== 1'b0) begin
         errors++; $display("FAIL %s idle_lines got mosi=%b sclk=%b exp 1/0", name, mosi, sclk);
      end
      reg_rd(2'd1, rd);
      checks++;
      if (rd !== exp_rx) begin
         errors++; $display("FAIL %s rx_data got %h exp %h", name, rd, exp_rx);
      end
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      nres = 1'b0; stb = 1'b0; rw = 1'b1; a = 2'd0; di = 8'd0;
      loopback = 1'b1; miso_drv = 1'b1; miso_pat = 8'hFF;
      repeat (3) @(negedge clk);
      checks++;
      if ({sclk, mosi, nsd0, nsd1, busy} !== 5'b01110) begin
         errors++;
         $display("FAIL reset_pins got sclk/mosi/nsd0/nsd1/busy=%b exp 01110",
                  {sclk, mosi, nsd0, nsd1, busy});
      end
      nres = 1'b1;
      reg_rd(2'd0, rd);
      checks++;
      if (rd !== 8'h03) begin errors++; $display("FAIL reset_ctrl got %h exp 03", rd); end
      reg_rd(2'd1, rd);
      checks++;
      if (rd !== 8'hFF) begin errors++; $display("FAIL reset_data got %h exp ff", rd); end
      reg_rd(2'd2, rd);
      checks++;
      if (rd !== 8'd59) begin errors++; $display("FAIL reset_div got %0d exp 59", rd); end
      reg_rd(2'd3, rd);
      checks++;
      if (rd !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", rd); end
   endtask

   task automatic test_transfers();
      do_xfer(0, 1'b1, 8'hA5, 1'b1, 8'h00, "a5_div0_loop");
      do_xfer(3, 1'b1, 8'h00, 1'b0, 8'hFF, "div3_miso1");
      for (int i = 0; i < 4; i++) begin
         do_xfer(int'($urandom_range(0, 3)), 1'b1, 8'($urandom), 1'($urandom),
                 8'($urandom), "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd, tx1;
      tx1 = 8'($urandom);
      reg_wr(2'd2, 8'd1);
      loopback = 1'b1;
      reg_wr(2'd1, tx1);
      reg_wr(2'd1, ~tx1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
      wait_idle("b2b");
      reg_rd(2'd3, rd);
      checks++;
      if (rd !== 8'h40) begin errors++; $display("FAIL b2b_status1 got %h exp 40", rd); end
      reg_rd(2'd3, rd);
      checks++;
      if (rd !== 8'h00) begin errors++; $display("FAIL b2b_status2 got %h exp 00", rd); end
      reg_rd(2'd1, rd);
      checks++;
      if (rd !== tx1) begin errors++; $display("FAIL b2b_rx got %h exp %h", rd, tx1); end
      exp_rx = tx1;
   endtask

   task automatic test_div_while_busy();
      int         rem;
      logic [7:0] rd;
      reg_wr(2'd2, 8'd0);
      loopback = 1'b1;
      reg_wr(2'd1, 8'h5A);
      reg_wr(2'd2, 8'd2);
      rem = 0;
      while (busy === 1'b1 && rem < 1000) begin rem++; @(negedge clk); end
      checks++;
      if (rem !== 14) begin errors++; $display("FAIL divbusy_remaining got %0d exp 14", rem); end
      reg_rd(2'd2, rd);
      checks++;
      if (rd !== 8'd2) begin errors++; $display("FAIL divbusy_div got %0d exp 2", rd); end
      do_xfer(2, 1'b0, 8'($urandom), 1'b1, 8'h00, "div2_next");
   endtask

   task automatic test_auto();
      logic [7:0] rd, prev;
      prev = exp_rx;
      loopback = 1'b1;
      reg_wr(2'd0, 8'h82);
      checks++;
      if (nsd0 !== 1'b0 || nsd1 !== 1'b1) begin
         errors++; $display("FAIL auto_selects got nsd0=%b nsd1=%b exp 0/1", nsd0, nsd1);
      end
      reg_rd(2'd1, rd);
      checks++;
      if (rd !== prev || busy !== 1'b1) begin
         errors++; $display("FAIL auto_start got data=%h busy=%b exp %h/1", rd, busy, prev);
      end
      reg_rd(2'd1, rd);
      checks++;
      if (rd !== prev) begin errors++; $display("FAIL auto_busy_read got %h exp %h", rd, prev); end
      reg_rd(2'd3, rd);
      checks++;
      if (rd !== 8'hC0) begin errors++; $display("FAIL auto_status got %h exp c0", rd); end
      wait_idle("auto");
      reg_rd(2'd3, rd);
      checks++;
      if (rd !== 8'h00) begin errors++; $display("FAIL auto_status_clr got %h exp 00", rd); end
      reg_wr(2'd0, 8'h02);
      reg_rd(2'd1, rd);
      checks++;
      if (rd !== 8'hFF || busy !== 1'b0) begin
         errors++; $display("FAIL auto_rx got %h busy=%b exp ff/0", rd, busy);
      end
   endtask

   task automatic test_reset_mid();
      int         rises, guard;
      logic       prev;
      logic [7:0] rd;
      do_xfer(0, 1'b1, 8'($urandom), 1'b0, 8'h3C, "pre_reset");
      reg_wr(2'd0, 8'h00);
      reg_wr(2'd2, 8'd1);
      loopback = 1'b1;
      reg_wr(2'd1, 8'h00);
      rises = 0; guard = 0; prev = sclk;
      while ((rises < 4 || sclk !== 1'b0) && guard < 1000) begin
         if (sclk === 1'b1 && prev === 1'b0) rises++;
         prev = sclk; guard++;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b1 || mosi !== 1'b0 || nsd0 !== 1'b0) begin
         errors++; $display("FAIL midrst_before got busy=%b mosi=%b nsd0=%b exp 1/0/0",
                            busy, mosi, nsd0);
      end
      nres = 1'b0;
      #1;
      checks++;
      if ({sclk, mosi, nsd0, nsd1, busy} !== 5'b01110) begin
         errors++;
         $display("FAIL midrst_pins got sclk/mosi/nsd0/nsd1/busy=%b exp 01110",
                  {sclk, mosi, nsd0, nsd1, busy});
      end
      @(negedge clk);
      nres = 1'b1;
      reg_rd(2'd1, rd);
      checks++;
      if (rd !== 8'hFF) begin errors++; $display("FAIL midrst_rx got %h exp ff", rd); end
   endtask

   initial begin
      exp_rx = 8'hFF;
      test_reset();
      test_transfers();
      test_back_to_back();
      test_div_while_busy();
      test_auto();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
